// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA timing generator. It issues a registered pixel request PIPE_LAT
// cycles ahead of the DAC and realigns sync/blank/colour to the renderer's reply.
module vga_timing_gen_p #(
  parameter int COLOR_W  = 10,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 11
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               iPattern_En,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oReq,
  output logic [CNT_W-1:0]   oCoord_X,
  output logic [CNT_W-1:0]   oCoord_Y,
  output logic               oFrame_Start,
  output logic               oLine_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK
);

  localparam int   H_TOTAL   = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL   = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int   H_SYNC_S  = H_ACT + H_FP;
  localparam int   H_SYNC_E  = H_SYNC_S + H_SYNC;
  localparam int   V_SYNC_S  = V_ACT + V_FP;
  localparam int   V_SYNC_E  = V_SYNC_S + V_SYNC;
  localparam int   BAR_W     = H_ACT / 8;
  localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;
  // Delay-line word: {pattern_en, pattern[2:0], vsync, hsync, active}
  localparam int   DL_W      = 7;

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             fs_q, fs_d, ls_q, ls_d;
  logic             hsa_q, hsa_d, vsa_q, vsa_d, pen_q, pen_d;
  logic [2:0]       pat_s;
  logic [PIPE_LAT-1:0][DL_W-1:0] dl_q, dl_d;
  logic [DL_W-1:0]  dl_out_s;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic             blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

  // Raster counters: Vc advances in the same cycle Hc wraps
  always_comb begin
    hc_d = hc_q + CNT_W'(1);
    vc_d = vc_q;
    if (hc_q == CNT_W'(H_TOTAL - 1)) begin
      hc_d = '0;
      if (vc_q == CNT_W'(V_TOTAL - 1)) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + CNT_W'(1);
      end
    end else begin
      vc_d = vc_q;
    end
  end

  // Request stage decoded straight from the counters
  always_comb begin
    req_d = (hc_q < CNT_W'(H_ACT)) && (vc_q < CNT_W'(V_ACT));
    x_d   = req_d ? hc_q : '0;
    y_d   = req_d ? vc_q : '0;
    fs_d  = (hc_q == '0) && (vc_q == '0);
    ls_d  = (hc_q == '0) && (vc_q < CNT_W'(V_ACT));
    hsa_d = (hc_q >= CNT_W'(H_SYNC_S)) && (hc_q < CNT_W'(H_SYNC_E));
    vsa_d = (vc_q >= CNT_W'(V_SYNC_S)) && (vc_q < CNT_W'(V_SYNC_E));
    pen_d = iPattern_En;
  end

  // Colour bars: bar 0 is white ({R,G,B}=7), bar 7 black
  always_comb begin
    pat_s = 3'd7 - 3'(x_q / CNT_W'(BAR_W));
  end

  // Delay line keeps sync/blank/pattern in step with the renderer latency
  always_comb begin
    dl_d    = dl_q;
    dl_d[0] = {pen_q, pat_s, vsa_q, hsa_q, req_q};
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
    dl_out_s = dl_q[PIPE_LAT-1];
  end

  // DAC stage: colour is forced to zero whenever the delayed pixel is blanked
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (dl_out_s[0]) begin
      if (dl_out_s[6]) begin
        r_d = {COLOR_W{dl_out_s[5]}};
        g_d = {COLOR_W{dl_out_s[4]}};
        b_d = {COLOR_W{dl_out_s[3]}};
      end else begin
        r_d = iRed;
        g_d = iGreen;
        b_d = iBlue;
      end
    end else begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
    blank_d = dl_out_s[0];
    hs_d    = dl_out_s[1] ^ SYNC_IDLE;
    vs_d    = dl_out_s[2] ^ SYNC_IDLE;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      hc_q    <= '0;
      vc_q    <= '0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      hsa_q   <= 1'b0;
      vsa_q   <= 1'b0;
      pen_q   <= 1'b0;
      dl_q    <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      hsa_q   <= hsa_d;
      vsa_q   <= vsa_d;
      pen_q   <= pen_d;
      dl_q    <= dl_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign oReq         = req_q;
  assign oCoord_X     = x_q;
  assign oCoord_Y     = y_q;
  assign oFrame_Start = fs_q;
  assign oLine_Start  = ls_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_H_SYNC  = hs_q;
  assign oVGA_V_SYNC  = vs_q;
  assign oVGA_BLANK   = blank_q;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Bench for vga_timing_gen_p: four configurations run side by side, each compared
// every cycle with a raster-position model derived from the cycle count since reset.
`timescale 1ns/1ps
module tb_vga_timing_gen_p;

  localparam int NI = 4;
  localparam int C_HA  [NI] = '{8, 8, 8, 640};
  localparam int C_HFP [NI] = '{2, 2, 2, 16};
  localparam int C_HS  [NI] = '{3, 3, 3, 96};
  localparam int C_HBP [NI] = '{1, 1, 1, 48};
  localparam int C_VA  [NI] = '{4, 4, 4, 3};
  localparam int C_VFP [NI] = '{1, 1, 1, 1};
  localparam int C_VS  [NI] = '{1, 1, 1, 1};
  localparam int C_VBP [NI] = '{1, 1, 1, 1};
  localparam int C_SP  [NI] = '{0, 0, 1, 0};
  localparam int C_PL  [NI] = '{2, 1, 5, 3};
  // Hand-computed per-frame figures
  localparam int C_EFT  [NI] = '{98, 98, 98, 4800};
  localparam int C_ELS  [NI] = '{4, 4, 4, 3};
  localparam int C_EREQ [NI] = '{32, 32, 32, 1920};
  localparam int C_EHS  [NI] = '{21, 21, 21, 576};
  localparam int C_EVS  [NI] = '{14, 14, 14, 800};
  localparam int C_IDLE [NI] = '{1, 1, 0, 1};
  // Hand-computed colour-bar pixels
  localparam int C_LX1 [NI] = '{0, 3, 6, 100};
  localparam int C_LR  [NI] = '{1023, 1023, 0, 1023};
  localparam int C_LG  [NI] = '{1023, 0, 0, 1023};
  localparam int C_LB  [NI] = '{1023, 0, 1023, 0};
  localparam int C_LX2 [NI] = '{7, 7, 7, 600};

  logic clk;
  logic rst_n;
  logic pen;
  logic run;
  int   n = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic pen_hist [16];

  task automatic chk(input string nm, input int g, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s inst%0d n=%0d: got %0d, expected %0d", nm, g, n, act, exp);
    end
  endtask

  always #5 clk = ~clk;

  // Edge count since reset release and the pattern-enable seen at each edge
  always @(posedge clk) begin
    n <= rst_n ? n + 1 : 0;
    pen_hist[(rst_n ? n + 1 : 0) % 16] <= pen;
  end

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int HA  = C_HA[g];
    localparam int HFP = C_HFP[g];
    localparam int HSW = C_HS[g];
    localparam int VA  = C_VA[g];
    localparam int VFP = C_VFP[g];
    localparam int VSW = C_VS[g];
    localparam int PL  = C_PL[g];
    localparam int SP  = C_SP[g];
    localparam int HT  = HA + HFP + HSW + C_HBP[g];
    localparam int VT  = VA + VFP + VSW + C_VBP[g];
    localparam int FT  = HT * VT;

    logic        req, fs, ls, hs, vs, blank;
    logic [10:0] cx, cy;
    logic [9:0]  r, gr, b, ir, ig, ib;
    logic [7:0]  rv;
    logic [9:0]  rx [8];
    logic [9:0]  ry [8];
    int st_seen = 0, st_cyc = 0, st_ls = 0, st_req = 0, st_hs = 0, st_vs = 0, st_bl = 0;

    vga_timing_gen_p #(
      .COLOR_W(10), .H_ACT(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(C_HBP[g]),
      .V_ACT(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(C_VBP[g]),
      .SYNC_POL(SP), .PIPE_LAT(PL), .CNT_W(11)
    ) dut (
      .Clock(clk), .Resetn(rst_n), .iPattern_En(pen),
      .iRed(ir), .iGreen(ig), .iBlue(ib),
      .oReq(req), .oCoord_X(cx), .oCoord_Y(cy),
      .oFrame_Start(fs), .oLine_Start(ls),
      .oVGA_R(r), .oVGA_G(gr), .oVGA_B(b),
      .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(blank)
    );

    // Renderer: answers (X, Y, 0x155) exactly PL cycles after the request, junk otherwise
    always @(posedge clk) begin
      rv <= {rv[6:0], req};
      for (int i = 7; i > 0; i--) begin
        rx[i] <= rx[i-1];
        ry[i] <= ry[i-1];
      end
      rx[0] <= cx[9:0];
      ry[0] <= cy[9:0];
    end
    assign ir = rv[PL-1] ? rx[PL-1] : 10'h2A5;
    assign ig = rv[PL-1] ? ry[PL-1] : 10'h1C3;
    assign ib = rv[PL-1] ? 10'h155  : 10'h0F0;

    always @(negedge clk) begin
      int p, h, v, q, bits, er, eg, eb, ehs, evs;
      logic e_act, e_pen;
      if (run) begin
        if (n == 0) begin
          chk("req", g, req, 0);
          chk("coord_x", g, cx, 0);
          chk("coord_y", g, cy, 0);
          chk("frame_start", g, fs, 0);
          chk("line_start", g, ls, 0);
          chk("hsync_idle_lit", g, hs, C_IDLE[g]);
          chk("vsync_idle_lit", g, vs, C_IDLE[g]);
        end else begin
          p = (n - 1) % FT;
          h = p % HT;
          v = p / HT;
          e_act = (h < HA) && (v < VA);
          chk("req", g, req, e_act);
          chk("coord_x", g, cx, e_act ? h : 0);
          chk("coord_y", g, cy, e_act ? v : 0);
          chk("frame_start", g, fs, (h == 0) && (v == 0));
          chk("line_start", g, ls, (h == 0) && (v < VA));
        end

        q = n - PL - 2;
        if (q < 0) begin
          er = 0; eg = 0; eb = 0; e_act = 1'b0;
          ehs = 1 - SP; evs = 1 - SP;
        end else begin
          p = q % FT;
          h = p % HT;
          v = p / HT;
          e_act = (h < HA) && (v < VA);
          e_pen = pen_hist[(n - PL - 1) % 16];
          ehs = ((h >= HA + HFP) && (h < HA + HFP + HSW)) ? SP : 1 - SP;
          evs = ((v >= VA + VFP) && (v < VA + VFP + VSW)) ? SP : 1 - SP;
          if (!e_act) begin
            er = 0; eg = 0; eb = 0;
          end else if (e_pen) begin
            bits = 7 - h / (HA / 8);
            er = ((bits & 4) != 0) ? 1023 : 0;
            eg = ((bits & 2) != 0) ? 1023 : 0;
            eb = ((bits & 1) != 0) ? 1023 : 0;
          end else begin
            er = h; eg = v; eb = 341;
          end
          if (e_act && e_pen && h == C_LX1[g]) begin
            chk("bar_lit_r", g, r, C_LR[g]);
            chk("bar_lit_g", g, gr, C_LG[g]);
            chk("bar_lit_b", g, b, C_LB[g]);
          end
          if (e_act && e_pen && h == C_LX2[g]) begin
            chk("bar7_lit_r", g, r, 0);
            chk("bar7_lit_g", g, gr, 0);
            chk("bar7_lit_b", g, b, 0);
          end
        end
        chk("vga_r", g, r, er);
        chk("vga_g", g, gr, eg);
        chk("vga_b", g, b, eb);
        chk("vga_blank", g, blank, e_act);
        chk("vga_hsync", g, hs, ehs);
        chk("vga_vsync", g, vs, evs);

        // Whole-frame tallies between consecutive frame-start strobes
        if (n == 0) begin
          st_seen = 0;
        end else begin
          if (fs) begin
            if (st_seen >= 2) begin
              chk("frame_cycles", g, st_cyc, C_EFT[g]);
              chk("line_starts", g, st_ls, C_ELS[g]);
              chk("req_per_frame", g, st_req, C_EREQ[g]);
              chk("blank1_per_frame", g, st_bl, C_EREQ[g]);
              chk("hsync_active_cycles", g, st_hs, C_EHS[g]);
              chk("vsync_active_cycles", g, st_vs, C_EVS[g]);
            end
            st_seen++;
            st_cyc = 0; st_ls = 0; st_req = 0; st_hs = 0; st_vs = 0; st_bl = 0;
          end
          st_cyc++;
          st_ls  += int'(ls);
          st_req += int'(req);
          st_bl  += int'(blank);
          st_hs  += (int'(hs) == SP) ? 1 : 0;
          st_vs  += (int'(vs) == SP) ? 1 : 0;
        end
      end
    end
  end

  initial begin
    bit found;
    clk = 1'b0;
    rst_n = 1'b0;
    pen = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    pen = 1'b1;
    repeat (1500) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      pen = ~pen;
      repeat (37 + k * 53) @(negedge clk);
    end
    pen = 1'b1;
    // Reset while the 640-wide instance sits at Hc=300, Vc=1
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (n % 4800 == 1100) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reset_sync", 3, found, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
